// File: rtl/wb_req_master_pkg.sv
// ---------------------------------------------------------------------------
// wb_master_pkg
// Shared types and constants for the Wishbone request master.
//   wb_req_t       : one queued request {we, addr, data, sel} (69 bits)
//   wb_mst_state_e : bus FSM states
//   WB_AW/WB_DW/WB_SW : address, data and byte-select widths
// ---------------------------------------------------------------------------
package wb_master_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
        logic [WB_SW-1:0] sel;
    } wb_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } wb_mst_state_e;

endpackage

// File: rtl/wb_req_fifo.sv
// ---------------------------------------------------------------------------
// wb_req_fifo
// Synchronous command FIFO of wb_req_t entries. Head entry is presented
// combinationally on o_rdata; o_pop advances past it.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (pointers only)
//   i_push, i_wdata: write an entry (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_rdata        : head entry
//   o_full, o_empty: occupancy flags
// ---------------------------------------------------------------------------
module wb_req_fifo
    import wb_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_push,
    input  wb_req_t i_wdata,
    input  logic    i_pop,
    output wb_req_t o_rdata,
    output logic    o_full,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    wb_req_t     r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/wb_req_master.sv
// ---------------------------------------------------------------------------
// wb_req_master
// Wishbone classic-cycle master. Requests are queued in wb_req_fifo and
// issued one bus cycle at a time; each produces exactly one response
// (read data, bus error or timeout) on the rsp_* valid/ready port.
//   clk_i, rst_i               : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    : request handshake (ready = FIFO not full)
//   req_we_i/addr/data/sel     : request fields
//   rsp_valid_o/rsp_ready_i    : response handshake
//   rsp_data_o/err_o/timeout_o : response fields
//   wb_*                       : Wishbone master port
//   busy_o                     : FIFO non-empty or FSM not idle
// ---------------------------------------------------------------------------
module wb_req_master
    import wb_master_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [WB_AW-1:0] req_addr_i,
    input  logic [WB_DW-1:0] req_data_i,
    input  logic [WB_SW-1:0] req_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WB_DW-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic             rsp_timeout_o,
    output logic [WB_AW-1:0] wb_addr_o,
    output logic [WB_DW-1:0] wb_data_o,
    output logic [WB_SW-1:0] wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    input  logic [WB_DW-1:0] wb_data_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    output logic             busy_o
);

    // Counter value seen on the TIMEOUT-th edge with cyc high.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    wb_mst_state_e    r_state;
    logic [15:0]      r_tmo_cnt;
    logic [WB_AW-1:0] r_wb_addr;
    logic [WB_DW-1:0] r_wb_data;
    logic [WB_SW-1:0] r_wb_sel;
    logic             r_wb_we;
    logic             r_wb_cyc;
    logic             r_rsp_valid;
    logic [WB_DW-1:0] r_rsp_data;
    logic             r_rsp_err;
    logic             r_rsp_tmo;

    wb_req_t w_req_in;
    wb_req_t w_head;
    logic    w_full;
    logic    w_empty;
    logic    w_start;

    assign w_req_in = '{we: req_we_i, addr: req_addr_i, data: req_data_i, sel: req_sel_i};

    // A new cycle starts from IDLE, or straight out of RSP on the
    // acceptance edge, whenever a request is waiting.
    assign w_start = ~w_empty &&
                     ((r_state == IDLE) || (r_state == RSP && rsp_ready_i));

    wb_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_push  (req_valid_i),
        .i_wdata (w_req_in),
        .i_pop   (w_start),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_tmo_cnt   <= '0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_wb_sel    <= '0;
            r_wb_we     <= 1'b0;
            r_wb_cyc    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                BUS: begin
                    if (wb_err_i) begin
                        r_wb_cyc    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RSP;
                    end else if (wb_ack_i) begin
                        r_wb_cyc    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_wb_we ? '0 : wb_data_i;
                        r_state     <= RSP;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_wb_cyc    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_tmo   <= 1'b1;
                        r_state     <= RSP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_tmo   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Launch overrides the IDLE fallback taken on response acceptance.
            if (w_start) begin
                r_wb_addr <= w_head.addr;
                r_wb_data <= w_head.data;
                r_wb_sel  <= w_head.sel;
                r_wb_we   <= w_head.we;
                r_wb_cyc  <= 1'b1;
                r_tmo_cnt <= '0;
                r_state   <= BUS;
            end
        end
    end

    assign req_ready_o   = ~w_full;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_tmo;
    assign wb_addr_o     = r_wb_addr;
    assign wb_data_o     = r_wb_data;
    assign wb_sel_o      = r_wb_sel;
    assign wb_we_o       = r_wb_we;
    assign wb_cyc_o      = r_wb_cyc;
    assign wb_stb_o      = r_wb_cyc;
    assign busy_o        = ~w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_wb_req_master.sv
// ---------------------------------------------------------------------------
// tb_wb_req_master
// Directed bench for wb_req_master (FIFO_DEPTH=4, TIMEOUT=8). A one-word
// slave responds with ack and/or err whenever the matching enable is set.
// ---------------------------------------------------------------------------
module tb_wb_req_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy_o;

    logic        ack_en = 1'b0;
    logic        err_en = 1'b0;
    logic [31:0] slv_mem = 32'h0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    wb_req_master #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_addr_i    (req_addr_i),
        .req_data_i    (req_data_i),
        .req_sel_i     (req_sel_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .wb_addr_o     (wb_addr_o),
        .wb_data_o     (wb_data_o),
        .wb_sel_o      (wb_sel_o),
        .wb_we_o       (wb_we_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_data_i     (wb_data_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i),
        .busy_o        (busy_o)
    );

    // Zero-wait slave holding a single word.
    assign wb_ack_i  = ack_en & wb_cyc_o & wb_stb_o;
    assign wb_err_i  = err_en & wb_cyc_o & wb_stb_o;
    assign wb_data_i = slv_mem;

    always @(posedge clk_i) begin
        if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && wb_we_o)
            slv_mem <= wb_data_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int   cnt;
        int   idx;
        logic stable;
        logic stale;

        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h0;
        req_data_i  = 32'h0;
        req_sel_i   = 4'h0;
        rsp_ready_i = 1'b0;
        repeat (3) step;

        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 1'b1;
        step;

        // Write then read at 0x100, zero-wait slave.
        ack_en      = 1'b1;
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h0000_0100;
        req_data_i  = 32'hDEAD_BEEF;
        req_sel_i   = 4'hF;
        step;
        req_we_i    = 1'b0;
        req_data_i  = 32'h0;
        step;
        req_valid_i = 1'b0;
        chk("wr_cyc", wb_cyc_o, 1);
        chk("wr_stb", wb_stb_o, 1);
        chk("wr_we", wb_we_o, 1);
        chk("wr_addr", wb_addr_o, 32'h0000_0100);
        chk("wr_data", wb_data_o, 32'hDEAD_BEEF);
        chk("wr_sel", wb_sel_o, 4'hF);
        step;
        chk("wr_rsp_valid", rsp_valid_o, 1);
        chk("wr_rsp_data", rsp_data_o, 0);
        chk("wr_cyc_drop", wb_cyc_o, 0);
        step;
        chk("rd_cyc_b2b", wb_cyc_o, 1);
        chk("rd_we", wb_we_o, 0);
        step;
        chk("rd_rsp_valid", rsp_valid_o, 1);
        chk("rd_rsp_data", rsp_data_o, 32'hDEAD_BEEF);
        chk("rd_rsp_err", rsp_err_o, 0);
        step;
        chk("rd_done_valid", rsp_valid_o, 0);
        chk("rd_done_busy", busy_o, 0);

        // ack and err on the same edge: err wins, no data captured.
        err_en      = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0000_0200;
        step;
        req_valid_i = 1'b0;
        step;
        chk("err_cyc", wb_cyc_o, 1);
        step;
        chk("err_rsp_valid", rsp_valid_o, 1);
        chk("err_rsp_err", rsp_err_o, 1);
        chk("err_rsp_data", rsp_data_o, 0);
        chk("err_rsp_tmo", rsp_timeout_o, 0);
        step;
        chk("err_cleared", rsp_err_o, 0);
        err_en = 1'b0;

        // Stalled slave: timeout after 8 cycles, then queued write runs.
        ack_en      = 1'b0;
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h0000_0300;
        step;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h0000_0304;
        req_data_i  = 32'h1234_5678;
        step;
        req_valid_i = 1'b0;
        cnt = 0;
        while (wb_cyc_o && cnt < 50) begin
            cnt++;
            step;
        end
        chk("tmo_cyc_len", cnt, 8);
        chk("tmo_rsp_valid", rsp_valid_o, 1);
        chk("tmo_flag", rsp_timeout_o, 1);
        chk("tmo_err", rsp_err_o, 0);
        chk("tmo_data", rsp_data_o, 0);
        ack_en      = 1'b1;
        rsp_ready_i = 1'b1;
        step;
        chk("tmo_next_cyc", wb_cyc_o, 1);
        chk("tmo_next_addr", wb_addr_o, 32'h0000_0304);
        chk("tmo_flag_clr", rsp_timeout_o, 0);
        step;
        chk("tmo_next_rsp", rsp_valid_o, 1);
        chk("tmo_next_tmo", rsp_timeout_o, 0);
        step;

        // Response back-pressure for 10 cycles with 2 requests queued.
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_data_i  = 32'h0;
        req_addr_i  = 32'h0000_0100;
        step;
        req_addr_i  = 32'h0000_0104;
        step;
        req_valid_i = 1'b0;
        step;
        chk("bp_rsp_valid", rsp_valid_o, 1);
        chk("bp_rsp_data", rsp_data_o, 32'h1234_5678);
        stable = 1'b1;
        repeat (10) begin
            step;
            if (!rsp_valid_o || rsp_data_o !== 32'h1234_5678 || wb_cyc_o) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        rsp_ready_i = 1'b1;
        step;
        chk("bp_second_cyc", wb_cyc_o, 1);
        chk("bp_second_addr", wb_addr_o, 32'h0000_0104);
        step;
        chk("bp_second_rsp", rsp_valid_o, 1);
        step;
        chk("bp_idle", busy_o, 0);

        // FIFO full: hold a response so nothing pops, then push 5.
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0000_0500;
        step;
        req_valid_i = 1'b0;
        step;
        step;
        chk("full_pending_rsp", rsp_valid_o, 1);
        ack_en      = 1'b0;
        req_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr_i = 32'h0000_0400 + 32'(4 * i);
            step;
        end
        req_addr_i = 32'h0000_0410;
        chk("full_ready_low", req_ready_o, 0);
        step;
        chk("full_held", req_ready_o, 0);
        rsp_ready_i = 1'b1;
        step;
        chk("full_after_pop", req_ready_o, 1);
        chk("full_pop_addr", wb_addr_o, 32'h0000_0400);
        step;
        req_valid_i = 1'b0;
        chk("full_fifth_taken", req_ready_o, 0);
        ack_en = 1'b1;
        idx = 0;
        for (int k = 0; k < 40 && busy_o; k++) begin
            if (wb_cyc_o) begin
                chk("drain_addr", wb_addr_o, 32'h0000_0400 + 32'(4 * idx));
                idx++;
            end
            step;
        end
        chk("drain_count", idx, 5);
        chk("drain_idle", busy_o, 0);

        // Reset asserted mid-BUS with another request queued.
        ack_en      = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0000_0600;
        step;
        req_addr_i  = 32'h0000_0604;
        step;
        req_valid_i = 1'b0;
        chk("mid_cyc", wb_cyc_o, 1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_cyc", wb_cyc_o, 0);
        chk("mid_rst_stb", wb_stb_o, 0);
        chk("mid_rst_valid", rsp_valid_o, 0);
        chk("mid_rst_ready", req_ready_o, 1);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_addr", wb_addr_o, 0);
        step;
        step;
        rst_i = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            step;
            if (wb_cyc_o || busy_o) stale = 1'b1;
        end
        chk("no_stale_cycle", stale, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_req_master.md
# wb_req_master

Wishbone classic-cycle master that drives the memory controller's Wishbone slave port (`wb_*` signals, 32-bit address and data, 4-bit byte select). Upstream agents push read/write requests through a valid/ready port into a small command FIFO. The block issues one Wishbone cycle at a time and returns one response per request (read data, bus error, or timeout) on a valid/ready response port. It is the stage directly upstream of the controller's slave interface, and the bench uses it as the reference bus master.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4 — command FIFO entries; power of two, minimum 2.
- `TIMEOUT`, default 255 — maximum cycles `wb_cyc_o` stays high without `wb_ack_i`/`wb_err_i`; range 1..65535.

Ports (clock and reset first):
- `clk_i`  in  1  — single clock; all logic on the rising edge.
- `rst_i`  in  1  — asynchronous, active-low reset.
- `req_valid_i`  in  1  — request valid.
- `req_ready_o`  out  1  — FIFO not full.
- `req_we_i`  in  1  — 1 = write, 0 = read.
- `req_addr_i`  in  32  — byte address.
- `req_data_i`  in  32  — write data.
- `req_sel_i`  in  4  — byte lane enables.
- `rsp_valid_o`  out  1  — response valid.
- `rsp_ready_i`  in  1  — response accepted.
- `rsp_data_o`  out  32  — read data; 0 for writes, errors and timeouts.
- `rsp_err_o`  out  1  — slave returned `wb_err_i`.
- `rsp_timeout_o`  out  1  — cycle aborted by timeout.
- `wb_addr_o`, `wb_data_o`  out  32 each; `wb_sel_o`  out  4; `wb_we_o`, `wb_cyc_o`, `wb_stb_o`  out  1 each.
- `wb_data_i`  in  32; `wb_ack_i`, `wb_err_i`  in  1 each.
- `busy_o`  out  1 — FIFO non-empty, or FSM not in IDLE.

## Operation
- **Push:** a request is pushed on the rising edge where `req_valid_i & req_ready_o`.
  - `req_ready_o = !full`. It depends on occupancy only; a same-cycle pop does not make a full FIFO ready.
- **FSM states:** IDLE, BUS, RSP.
- **IDLE → BUS:** taken when the FIFO is non-empty. The head entry is popped, and the `wb_addr_o`/`wb_data_o`/`wb_sel_o`/`wb_we_o` registers load from it. `wb_cyc_o` and `wb_stb_o` are registered to 1.
- **BUS:** `wb_cyc_o`, `wb_stb_o` and all `wb_*` outputs are held stable. The timeout counter increments each cycle.
  - Edge sampling `wb_err_i=1` → RSP with `rsp_err_o=1`. Err has priority when `ack` and `err` arrive together.
  - Else edge sampling `wb_ack_i=1` → RSP. A read captures `wb_data_i` into `rsp_data_o`.
  - Else, when the counter reaches `TIMEOUT` → RSP with `rsp_timeout_o=1`.
  - Any exit from BUS clears `wb_cyc_o` and `wb_stb_o` on the same registered update.
- **RSP:** `rsp_valid_o=1`, and the response fields are held until `rsp_ready_i`. On acceptance → IDLE and the response fields clear.
- Exactly one Wishbone cycle is outstanding at a time. No new cycle starts until the previous response has been accepted.
- `wb_ack_i`/`wb_err_i` outside BUS are ignored.
- Address/data widths are fixed; no misalignment checks. `wb_sel_o` passes `req_sel_i` unmodified.
- **Reset (asserted at any time, including mid-cycle):** all outputs go to 0 immediately, except `req_ready_o`, which goes to 1. FIFO pointers clear, in-flight requests are discarded, FSM → IDLE, and the timeout counter clears.

## Timing
- Push at edge N. The FIFO entry is visible after N. The pop and `wb_cyc_o`/`wb_stb_o`=1 occur at edge N+1. Pushing into an empty FIFO therefore has 1 cycle of latency to the bus.
- Ack sampled high at edge M → `wb_cyc_o=0` and `rsp_valid_o=1` after M. The response is accepted at the first edge ≥ M+1 where `rsp_ready_i=1`; the next bus cycle may start at that same edge if the FIFO is non-empty.
- Zero-wait-state slave (ack at the first edge with stb high): 2 bus cycles per transfer when `rsp_ready_i` is tied high.
- Timeout: the cycle aborts after exactly `TIMEOUT` clocks with `wb_cyc_o` high.
- The FIFO holds exactly `FIFO_DEPTH` entries. Read/write pointers wrap modulo `FIFO_DEPTH`, with an extra MSB for full/empty.

## Structure
- Package `wb_master_pkg`:
  - typedef `wb_req_t` (we, addr, data, sel — 69 bits)
  - enum `wb_mst_state_e` {IDLE, BUS, RSP}
  - constants `WB_AW=32`, `WB_DW=32`, `WB_SW=4`
- Sub-module `wb_req_fifo`: synchronous FIFO of `wb_req_t`, parameterised by depth, with `full`/`empty` outputs. The FSM and timeout counter stay in the top.

## Test plan
- Reset mid-BUS: assert `rst_i=0` while `wb_cyc_o=1` → `wb_cyc_o`, `wb_stb_o` and `rsp_valid_o` go to 0 immediately, `req_ready_o=1`, `busy_o=0`. After release, no stale cycle is issued.
- Write then read at `0x0000_0100`, data `0xDEAD_BEEF`, sel `0xF`, zero-wait slave → write cycle with `wb_we_o=1`. The read response has `rsp_data_o=0xDEAD_BEEF`, `rsp_err_o=0`.
- Push 5 requests with `FIFO_DEPTH=4` and the slave stalled → `req_ready_o=0` after 4 are queued (the 5th is held). The 5th is accepted the cycle after the first pop.
- Slave asserts `wb_ack_i` and `wb_err_i` on the same edge → `rsp_err_o=1`, `rsp_data_o=0`.
- Slave never acks, `TIMEOUT=8` → `wb_cyc_o` high for exactly 8 cycles, then `rsp_timeout_o=1`. The next queued request still executes.
- `rsp_ready_i` held low for 10 cycles with 2 requests queued → the first response is stable throughout, and no second `wb_cyc_o` is issued until acceptance.
